// File: rtl/a51_stream_engine.sv
// a51_stream_engine
//   Parallel-load A5/1 keystream engine. Loads a key and frame number, runs
//   key mix, frame mix and warm-up on the three majority-clocked LFSRs
//   (19/22/23 bits), then emits keystream packed into OUT_WIDTH-bit words
//   over a valid/ready handshake. The LFSRs freeze under backpressure.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   start           begins a run (sampled in IDLE only)
//   key_in          key, mixed LSB first, captured on accepted start
//   frame_in        frame number, mixed LSB first, captured on accepted start
//   frame_load      (A51_FRAME_AUTOINC_EN only) 1: use frame_in, 0: use the
//                   internal auto-incrementing frame register
//   busy            high in every state except IDLE
//   phase           IDLE=0 KEYMIX=1 FRAMEMIX=2 WARMUP=3 STREAM=4 DRAIN=5
//   out_data        keystream word, first generated bit in the MSB
//   out_valid       out_data holds a word
//   out_ready       consumer accepts on out_valid && out_ready
//   done            one-cycle pulse after the final word is accepted
//
// Optional feature macro: A51_FRAME_AUTOINC_EN
module a51_stream_engine #(
  parameter int unsigned KEY_BITS      = 64,
  parameter int unsigned FRAME_BITS    = 22,
  parameter int unsigned WARMUP_CYCLES = 100,
  parameter int unsigned STREAM_BITS   = 228,
  parameter int unsigned OUT_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_BITS-1:0]   key_in,
  input  logic [FRAME_BITS-1:0] frame_in,
`ifdef A51_FRAME_AUTOINC_EN
  input  logic                  frame_load,
`endif
  output logic                  busy,
  output logic [2:0]            phase,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done
);

  // Only whole words are generated; any remainder of STREAM_BITS that does
  // not fill a word is never produced.
  localparam int unsigned NUM_WORDS = STREAM_BITS / OUT_WIDTH;
  localparam int unsigned GEN_BITS  = NUM_WORDS * OUT_WIDTH;
  localparam int unsigned MAX_KF    = (KEY_BITS > FRAME_BITS) ? KEY_BITS : FRAME_BITS;
  localparam int unsigned MAX_WG    = (WARMUP_CYCLES > GEN_BITS) ? WARMUP_CYCLES : GEN_BITS;
  localparam int unsigned MAX_LEN   = (MAX_KF > MAX_WG) ? MAX_KF : MAX_WG;
  localparam int unsigned CNT_W     = $clog2(MAX_LEN + 1);
  localparam int unsigned SH_W      = OUT_WIDTH - 1;
  localparam int unsigned SC_W      = $clog2(OUT_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_KEYMIX   = 3'd1,
    S_FRAMEMIX = 3'd2,
    S_WARMUP   = 3'd3,
    S_STREAM   = 3'd4,
    S_DRAIN    = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [18:0]           r1_q, r1_d, mr1;
  logic [21:0]           r2_q, r2_d, mr2;
  logic [22:0]           r3_q, r3_d, mr3;
  logic [KEY_BITS-1:0]   key_sh_q, key_sh_d;
  logic [FRAME_BITS-1:0] frame_sh_q, frame_sh_d, frame_sel;
  logic [SH_W-1:0]       sh_q, sh_d;
  logic [SC_W-1:0]       sh_cnt_q, sh_cnt_d;
  logic [OUT_WIDTH-1:0]  hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  done_q, done_d;
`ifdef A51_FRAME_AUTOINC_EN
  logic [FRAME_BITS-1:0] frame_reg_q, frame_reg_d;
`endif

  logic fb1, fb2, fb3, maj, accept, word_end, stall, gen, mix_bit, ks_bit;

  // LFSR feedback, majority step and handshake qualifiers
  always_comb begin
    fb1      = r1_q[18] ^ r1_q[17] ^ r1_q[16] ^ r1_q[13];
    fb2      = r2_q[21] ^ r2_q[20];
    fb3      = r3_q[22] ^ r3_q[21] ^ r3_q[20] ^ r3_q[7];
    maj      = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
    mr1      = (r1_q[8]  == maj) ? {r1_q[17:0], fb1} : r1_q;
    mr2      = (r2_q[10] == maj) ? {r2_q[20:0], fb2} : r2_q;
    mr3      = (r3_q[10] == maj) ? {r3_q[21:0], fb3} : r3_q;
    accept   = hold_valid_q & out_ready;
    // The word-completing bit goes straight to the holding register, so the
    // shift register only ever holds OUT_WIDTH-1 bits.
    word_end = (sh_cnt_q == SC_W'(OUT_WIDTH - 1));
    stall    = word_end & hold_valid_q & ~out_ready;
    gen      = (state_q == S_STREAM) & ~stall;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_KEYMIX;
      S_KEYMIX:   if (cnt_q == CNT_W'(KEY_BITS - 1)) state_d = S_FRAMEMIX;
      S_FRAMEMIX: if (cnt_q == CNT_W'(FRAME_BITS - 1))
                    state_d = (WARMUP_CYCLES == 0) ? S_STREAM : S_WARMUP;
      S_WARMUP:   if (cnt_q == CNT_W'(WARMUP_CYCLES - 1)) state_d = S_STREAM;
      S_STREAM:   if (gen && (cnt_q == CNT_W'(GEN_BITS - 1))) state_d = S_DRAIN;
      S_DRAIN:    if (accept) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q != S_IDLE);
    phase     = state_q;
    out_valid = hold_valid_q;
    out_data  = hold_q;
    done      = done_q;
  end

  // Datapath next-state
  always_comb begin
    r1_d         = r1_q;
    r2_d         = r2_q;
    r3_d         = r3_q;
    key_sh_d     = key_sh_q;
    frame_sh_d   = frame_sh_q;
    sh_d         = sh_q;
    sh_cnt_d     = sh_cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q & ~accept;
    done_d       = (state_q == S_DRAIN) & accept;
    cnt_d        = cnt_q;
    mix_bit      = 1'b0;
    ks_bit       = 1'b0;
`ifdef A51_FRAME_AUTOINC_EN
    frame_reg_d  = done_d ? frame_reg_q + 1'b1 : frame_reg_q;
    frame_sel    = frame_load ? frame_in : frame_reg_q;
`else
    frame_sel    = frame_in;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_sh_d   = key_in;
          frame_sh_d = frame_sel;
          r1_d       = '0;
          r2_d       = '0;
          r3_d       = '0;
          sh_d       = '0;
          sh_cnt_d   = '0;
`ifdef A51_FRAME_AUTOINC_EN
          if (frame_load) frame_reg_d = frame_in;
`endif
        end
      end
      S_KEYMIX, S_FRAMEMIX: begin
        // Key and frame are consumed from bit 0 of right-shifting copies.
        mix_bit = (state_q == S_KEYMIX) ? key_sh_q[0] : frame_sh_q[0];
        r1_d    = {r1_q[17:0], fb1 ^ mix_bit};
        r2_d    = {r2_q[20:0], fb2 ^ mix_bit};
        r3_d    = {r3_q[21:0], fb3 ^ mix_bit};
        if (state_q == S_KEYMIX) key_sh_d   = key_sh_q >> 1;
        else                     frame_sh_d = frame_sh_q >> 1;
        cnt_d   = cnt_q + 1'b1;
      end
      S_WARMUP: begin
        r1_d  = mr1;
        r2_d  = mr2;
        r3_d  = mr3;
        cnt_d = cnt_q + 1'b1;
      end
      S_STREAM: begin
        if (gen) begin
          r1_d   = mr1;
          r2_d   = mr2;
          r3_d   = mr3;
          ks_bit = mr1[18] ^ mr2[21] ^ mr3[22];
          cnt_d  = cnt_q + 1'b1;
          if (word_end) begin
            hold_d       = {sh_q, ks_bit};
            hold_valid_d = 1'b1;
            sh_cnt_d     = '0;
          end else begin
            sh_d     = SH_W'({sh_q, ks_bit});
            sh_cnt_d = sh_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      r1_q         <= '0;
      r2_q         <= '0;
      r3_q         <= '0;
      key_sh_q     <= '0;
      frame_sh_q   <= '0;
      sh_q         <= '0;
      sh_cnt_q     <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef A51_FRAME_AUTOINC_EN
      frame_reg_q  <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      r1_q         <= r1_d;
      r2_q         <= r2_d;
      r3_q         <= r3_d;
      key_sh_q     <= key_sh_d;
      frame_sh_q   <= frame_sh_d;
      sh_q         <= sh_d;
      sh_cnt_q     <= sh_cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      done_q       <= done_d;
`ifdef A51_FRAME_AUTOINC_EN
      frame_reg_q  <= frame_reg_d;
`endif
    end
  end

endmodule
